fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Pipeline control block that produces the 2-bit operand select codes driving the execute-stage 3-input operand muxes.
- Also generates the load-use stall and bubble controls.
- Tracks the destination register of the instructions in EX, MEM and WB internally.
- Sits between the decode stage and the ID/EX pipeline register of the CPU.

Parameters:
REG_ADDR_W, 5, register-file address width
SEL_W, 2, operand select width (fixed encoding, see Behaviour)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  decode stage holds a real instruction
id_rs1  in  REG_ADDR_W  source register 1 of decode instruction
id_rs2  in  REG_ADDR_W  source register 2 of decode instruction
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  REG_ADDR_W  destination register of decode instruction
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
flush  in  1  branch/jump redirect; kill decode and EX instructions
fwd_a_sel  out  SEL_W  operand A select for instruction now in EX
fwd_b_sel  out  SEL_W  operand B select for instruction now in EX
stall  out  1  hold PC and IF/ID register this cycle
bubble  out  1  inject NOP into ID/EX this cycle
stall_count  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Select encoding:
  - 2'b00 = register-file value
  - 2'b01 = WB-stage result
  - 2'b10 = MEM-stage ALU result
  - 2'b11 is never driven.
- Shadow slots EX, MEM, WB. Each slot holds {valid, rd, reg_write, mem_read}.
- FSM states RUN, STALL. Reset state RUN.
- Reset (rst=1 at clk edge):
  - all slots invalid
  - fwd_a_sel = fwd_b_sel = 2'b00
  - FSM to RUN
  - stall_count = 0
  - reset mid-stall abandons the stall.
- Load-use detect (combinational, "lu"):
  - Asserted when EX.valid & EX.mem_read & EX.reg_write & EX.rd != 0, and either
    - id_valid & id_use_rs1 & id_rs1 == EX.rd, or
    - id_valid & id_use_rs2 & id_rs2 == EX.rd.
- stall = bubble = lu & ~flush, asserted the same cycle as detection.
- FSM:
  - RUN -> STALL on stall.
  - STALL -> RUN unconditionally the next cycle. By then the load has moved to MEM, so lu cannot re-fire for that load.
  - Maximum load-use stall is 1 cycle.
- Slot update each clk edge (no rst):
  - WB <= MEM
  - MEM <= EX
  - EX <= decode info with valid = id_valid & ~bubble & ~flush.
- Forward select, registered. Applies to the instruction entering EX, computed against the current slots; shown for operand A, B identical with rs2:
  - 2'b10 if EX.valid & EX.reg_write & EX.rd != 0 & EX.rd == id_rs1 & id_use_rs1
  - else 2'b01 if the same test matches against MEM
  - else 2'b00.
  - The younger producer (EX slot) wins over MEM.
  - On bubble or flush, both selects register 2'b00.
- Register 0 is never forwarded or stalled on.
- flush and lu in the same cycle: flush wins, so stall = bubble = 0 and the EX slot becomes invalid.
- Latency: selects valid in the same cycle the instruction occupies EX, i.e. registered one cycle after its decode cycle.

Optional Feature:
- Macro HAZARD_STALL_COUNT_EN.
- Defined:
  - stall_count increments by 1 on every cycle with stall=1.
  - Wraps from 32'hFFFF_FFFF to 0.
  - Cleared by rst.
- Undefined: no counter logic is built and stall_count is tied to 32'h0.

Decomposition:
- Shared package / header cpu_pipe_pkg:
  - select codes SEL_RF=2'b00, SEL_WB=2'b01, SEL_MEM=2'b10
  - REG_ADDR_W default
  - shadow-slot struct/field widths.
- One natural sub-module, fwd_sel_gen: purely combinational compare of one source register against the EX/MEM slots, returning a select code. Instantiated twice (A and B).

Test Plan:
- ALU chain: add x5 in EX, next instr reads rs1=x5 -> fwd_a_sel=2'b10 in its EX cycle, stall=0.
- Distance 2: producer x7 now in MEM, consumer rs2=x7 -> fwd_b_sel=2'b01. Both EX and MEM write x7 -> 2'b10.
- Load-use: lw x3 in EX, decode reads rs1=x3 -> stall=bubble=1 for exactly 1 cycle. Consumer then gets fwd_a_sel=2'b01.
- Register x0: producer rd=0 with reg_write=1, consumer rs1=0 -> selects 2'b00, no stall even if producer is a load.
- flush coinciding with a load-use hazard -> stall=0, EX slot invalid, no forwarding from killed instr next cycle. rst asserted during STALL -> all outputs 0, FSM in RUN.
- With HAZARD_STALL_COUNT_EN: 3 load-use hazards -> stall_count=3. Without the macro -> stall_count=0 throughout.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared operand-select codes and shadow-slot widths for the pipeline hazard logic.
package cpu_pipe_pkg;
   localparam int REG_ADDR_W_DEF = 5;
   localparam int SEL_CODE_W = 2;
   localparam logic [SEL_CODE_W-1:0] SEL_RF  = 2'b00;
   localparam logic [SEL_CODE_W-1:0] SEL_WB  = 2'b01;
   localparam logic [SEL_CODE_W-1:0] SEL_MEM = 2'b10;
   typedef enum logic {RUN, STALL} state_t;
endpackage

// File: rtl/fwd_sel_gen.sv
// fwd_sel_gen: compares one source register against the EX/MEM producers and returns its operand select.
module fwd_sel_gen
   import cpu_pipe_pkg::*;
#(
   parameter int W = REG_ADDR_W_DEF
) (
   input  logic [W-1:0]          rs,
   input  logic                  use_rs,
   input  logic                  ex_valid,
   input  logic [W-1:0]          ex_rd,
   input  logic                  ex_reg_write,
   input  logic                  mem_valid,
   input  logic [W-1:0]          mem_rd,
   input  logic                  mem_reg_write,
   output logic [SEL_CODE_W-1:0] sel
);
   logic ex_hit, mem_hit;
   always_comb begin
      ex_hit  = use_rs & ex_valid & ex_reg_write & (ex_rd != '0) & (ex_rd == rs);
      mem_hit = use_rs & mem_valid & mem_reg_write & (mem_rd != '0) & (mem_rd == rs);
      // the younger producer (EX) holds the newer value
      sel     = ex_hit ? SEL_MEM : mem_hit ? SEL_WB : SEL_RF;
   end
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX operand forwarding selects and load-use stall/bubble control.
// Define HAZARD_STALL_COUNT_EN to build the stall-cycle counter; otherwise stall_count is tied to zero.
module fwd_hazard_ctrl
   import cpu_pipe_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int SEL_W = SEL_CODE_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  flush,
   output logic [SEL_W-1:0]      fwd_a_sel,
   output logic [SEL_W-1:0]      fwd_b_sel,
   output logic                  stall,
   output logic                  bubble,
   output logic [31:0]           stall_count
);
   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
   } slot_t;
   slot_t ex;
   logic mem_valid, mem_reg_write;
   logic [REG_ADDR_W-1:0] mem_rd;
   state_t state;
   logic lu;
   logic [SEL_CODE_W-1:0] a_nxt, b_nxt;
   // after a stall EX holds the bubble, so lu is naturally quiet in STALL
   always_comb begin
      lu = (state == RUN) & ex.valid & ex.mem_read & ex.reg_write & (ex.rd != '0) & id_valid &
           ((id_use_rs1 & (id_rs1 == ex.rd)) | (id_use_rs2 & (id_rs2 == ex.rd)));
      stall  = lu & ~flush;
      bubble = stall;
   end
   fwd_sel_gen #(.W(REG_ADDR_W)) u_sel_a (
      .rs(id_rs1), .use_rs(id_use_rs1),
      .ex_valid(ex.valid), .ex_rd(ex.rd), .ex_reg_write(ex.reg_write),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .sel(a_nxt)
   );
   fwd_sel_gen #(.W(REG_ADDR_W)) u_sel_b (
      .rs(id_rs2), .use_rs(id_use_rs2),
      .ex_valid(ex.valid), .ex_rd(ex.rd), .ex_reg_write(ex.reg_write),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .sel(b_nxt)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         ex            <= '0;
         mem_valid     <= 1'b0;
         mem_rd        <= '0;
         mem_reg_write <= 1'b0;
         fwd_a_sel     <= SEL_RF;
         fwd_b_sel     <= SEL_RF;
         state         <= RUN;
      end else begin
         mem_valid     <= ex.valid;
         mem_rd        <= ex.rd;
         mem_reg_write <= ex.reg_write;
         ex            <= '{valid: id_valid & ~bubble & ~flush, rd: id_rd,
                            reg_write: id_reg_write, mem_read: id_mem_read};
         fwd_a_sel     <= (bubble | flush) ? SEL_RF : a_nxt;
         fwd_b_sel     <= (bubble | flush) ? SEL_RF : b_nxt;
         state         <= (state == RUN && stall) ? STALL : RUN;
      end
   end
`ifdef HAZARD_STALL_COUNT_EN
   always_ff @(posedge clk)
      stall_count <= rst ? 32'h0 : stall_count + 32'(stall);
`else
   assign stall_count = 32'h0;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed scenarios plus randomized traffic checked against a pipeline-history model.
module tb_fwd_hazard_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   logic id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0, id_reg_write = 0, id_mem_read = 0, flush = 0;
   logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic stall, bubble;
   logic [31:0] stall_count;
   int errs = 0, checks = 0;
   typedef struct {bit v; bit [4:0] rd; bit w; bit m;} ent_t;
   ent_t hist[$];
   bit s_stall, s_bubble, e_stall;
   bit [1:0] e_a, e_b;
   bit [31:0] e_cnt = 0;
   always #5 clk = ~clk;
   fwd_hazard_ctrl dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .bubble(bubble),
      .stall_count(stall_count)
   );
   // hist[0] is the instruction now in EX, hist[1] the one in MEM
   function automatic ent_t slot(int i);
      ent_t e;
      e = '{default: 0};
      if (hist.size() > i) e = hist[i];
      return e;
   endfunction
   function automatic bit [1:0] fsel(bit [4:0] rs, bit u);
      ent_t x, y;
      x = slot(0);
      y = slot(1);
      if (!u || rs == 0) return 2'b00;
      if (x.v && x.w && x.rd == rs) return 2'b10;
      if (y.v && y.w && y.rd == rs) return 2'b01;
      return 2'b00;
   endfunction
   function automatic bit [31:0] cnt_exp();
`ifdef HAZARD_STALL_COUNT_EN
      return e_cnt;
`else
      return 32'h0;
`endif
   endfunction
   task automatic cyc(input bit v, input bit [4:0] r1, input bit [4:0] r2, input bit u1, input bit u2,
                      input bit [4:0] d, input bit w, input bit m, input bit f);
      ent_t x, n;
      id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
      id_rd = d; id_reg_write = w; id_mem_read = m; flush = f;
      @(negedge clk);
      s_stall = stall;
      s_bubble = bubble;
      x = slot(0);
      e_stall = x.v && x.m && x.w && x.rd != 0 && v && !f && ((u1 && r1 == x.rd) || (u2 && r2 == x.rd));
      @(posedge clk);
      #1;
      if (rst) begin
         hist.delete();
         e_a = 0; e_b = 0; e_cnt = 0;
      end else begin
         e_a = (e_stall || f) ? 2'b00 : fsel(r1, u1);
         e_b = (e_stall || f) ? 2'b00 : fsel(r2, u2);
         if (e_stall) e_cnt++;
         n.v = v && !e_stall && !f; n.rd = d; n.w = w; n.m = m;
         hist.push_front(n);
         if (hist.size() > 4) void'(hist.pop_back());
      end
   endtask
   task automatic do_reset();
      rst = 1;
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 0;
   endtask
   task automatic test_reset();
      do_reset();
      checks += 4;
      if (fwd_a_sel !== 2'b00) begin errs++; $display("FAIL reset_a got=%0d want=0", fwd_a_sel); end
      if (fwd_b_sel !== 2'b00) begin errs++; $display("FAIL reset_b got=%0d want=0", fwd_b_sel); end
      if (stall_count !== 32'h0) begin errs++; $display("FAIL reset_cnt got=%0d want=0", stall_count); end
      #1;
      if (stall !== 1'b0) begin errs++; $display("FAIL reset_stall got=%0d want=0", stall); end
   endtask
   task automatic test_alu_chain();
      do_reset();
      cyc(1, 1, 2, 0, 0, 5, 1, 0, 0);
      cyc(1, 5, 6, 1, 1, 8, 1, 0, 0);
      checks += 3;
      if (s_stall !== 1'b0) begin errs++; $display("FAIL alu_stall got=%0d want=0", s_stall); end
      if (fwd_a_sel !== 2'b10) begin errs++; $display("FAIL alu_a got=%0d want=2", fwd_a_sel); end
      if (fwd_b_sel !== 2'b00) begin errs++; $display("FAIL alu_b got=%0d want=0", fwd_b_sel); end
   endtask
   task automatic test_distance2();
      do_reset();
      cyc(1, 0, 0, 0, 0, 7, 1, 0, 0);
      cyc(1, 1, 2, 1, 1, 9, 1, 0, 0);
      cyc(1, 1, 7, 1, 1, 10, 1, 0, 0);
      checks += 3;
      if (fwd_b_sel !== 2'b01) begin errs++; $display("FAIL dist2_b got=%0d want=1", fwd_b_sel); end
      if (fwd_a_sel !== 2'b00) begin errs++; $display("FAIL dist2_a got=%0d want=0", fwd_a_sel); end
      cyc(1, 0, 0, 0, 0, 7, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 7, 1, 0, 0);
      cyc(1, 3, 7, 1, 1, 11, 1, 0, 0);
      if (fwd_b_sel !== 2'b10) begin errs++; $display("FAIL dist_both_b got=%0d want=2", fwd_b_sel); end
   endtask
   task automatic test_load_use();
      do_reset();
      cyc(1, 1, 0, 1, 0, 3, 1, 1, 0);
      cyc(1, 3, 4, 1, 1, 6, 1, 0, 0);
      checks += 5;
      if (s_stall !== 1'b1) begin errs++; $display("FAIL lu_stall got=%0d want=1", s_stall); end
      if (s_bubble !== 1'b1) begin errs++; $display("FAIL lu_bubble got=%0d want=1", s_bubble); end
      if (fwd_a_sel !== 2'b00) begin errs++; $display("FAIL lu_bubble_a got=%0d want=0", fwd_a_sel); end
      cyc(1, 3, 4, 1, 1, 6, 1, 0, 0);
      if (s_stall !== 1'b0) begin errs++; $display("FAIL lu_one_cycle got=%0d want=0", s_stall); end
      if (fwd_a_sel !== 2'b01) begin errs++; $display("FAIL lu_fwd_a got=%0d want=1", fwd_a_sel); end
   endtask
   task automatic test_x0();
      do_reset();
      cyc(1, 0, 0, 0, 0, 0, 1, 1, 0);
      cyc(1, 0, 0, 1, 1, 4, 1, 0, 0);
      checks += 3;
      if (s_stall !== 1'b0) begin errs++; $display("FAIL x0_stall got=%0d want=0", s_stall); end
      if (fwd_a_sel !== 2'b00) begin errs++; $display("FAIL x0_a got=%0d want=0", fwd_a_sel); end
      if (fwd_b_sel !== 2'b00) begin errs++; $display("FAIL x0_b got=%0d want=0", fwd_b_sel); end
   endtask
   task automatic test_flush();
      do_reset();
      cyc(1, 0, 0, 0, 0, 4, 1, 1, 0);
      cyc(1, 4, 0, 1, 0, 10, 1, 0, 1);
      checks += 6;
      if (s_stall !== 1'b0) begin errs++; $display("FAIL flush_stall got=%0d want=0", s_stall); end
      if (s_bubble !== 1'b0) begin errs++; $display("FAIL flush_bubble got=%0d want=0", s_bubble); end
      if (fwd_a_sel !== 2'b00) begin errs++; $display("FAIL flush_a got=%0d want=0", fwd_a_sel); end
      cyc(1, 10, 4, 1, 1, 12, 1, 0, 0);
      if (s_stall !== 1'b0) begin errs++; $display("FAIL flush_next_stall got=%0d want=0", s_stall); end
      if (fwd_a_sel !== 2'b00) begin errs++; $display("FAIL flush_killed_a got=%0d want=0", fwd_a_sel); end
      if (fwd_b_sel !== 2'b01) begin errs++; $display("FAIL flush_mem_b got=%0d want=1", fwd_b_sel); end
   endtask
   task automatic test_reset_mid_stall();
      do_reset();
      cyc(1, 0, 0, 0, 0, 3, 1, 1, 0);
      cyc(1, 3, 0, 1, 0, 5, 1, 0, 0);
      rst = 1;
      cyc(1, 3, 0, 1, 0, 5, 1, 0, 0);
      rst = 0;
      checks += 6;
      if (fwd_a_sel !== 2'b00) begin errs++; $display("FAIL rst_mid_a got=%0d want=0", fwd_a_sel); end
      if (stall_count !== 32'h0) begin errs++; $display("FAIL rst_mid_cnt got=%0d want=0", stall_count); end
      cyc(1, 3, 0, 1, 0, 5, 1, 0, 0);
      if (s_stall !== 1'b0) begin errs++; $display("FAIL rst_mid_stall got=%0d want=0", s_stall); end
      if (fwd_a_sel !== 2'b00) begin errs++; $display("FAIL rst_mid_fwd got=%0d want=0", fwd_a_sel); end
      cyc(1, 0, 0, 0, 0, 3, 1, 1, 0);
      cyc(1, 3, 0, 1, 0, 5, 1, 0, 0);
      if (s_stall !== 1'b1) begin errs++; $display("FAIL rst_mid_run got=%0d want=1", s_stall); end
      if (stall_count !== cnt_exp()) begin errs++; $display("FAIL rst_mid_cnt2 got=%0d want=%0d", stall_count, cnt_exp()); end
   endtask
   task automatic test_stall_count();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 0, 0, 3, 1, 1, 0);
         cyc(1, 1, 3, 0, 1, 6, 1, 0, 0);
         cyc(1, 1, 3, 0, 1, 6, 1, 0, 0);
      end
      checks++;
`ifdef HAZARD_STALL_COUNT_EN
      if (stall_count !== 32'd3) begin errs++; $display("FAIL cnt_three got=%0d want=3", stall_count); end
`else
      if (stall_count !== 32'd0) begin errs++; $display("FAIL cnt_off got=%0d want=0", stall_count); end
`endif
   endtask
   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         cyc($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
         checks += 5;
         if (s_stall !== e_stall) begin errs++; $display("FAIL rnd_stall i=%0d got=%0d want=%0d", i, s_stall, e_stall); end
         if (s_bubble !== e_stall) begin errs++; $display("FAIL rnd_bubble i=%0d got=%0d want=%0d", i, s_bubble, e_stall); end
         if (fwd_a_sel !== e_a) begin errs++; $display("FAIL rnd_a i=%0d got=%0d want=%0d", i, fwd_a_sel, e_a); end
         if (fwd_b_sel !== e_b) begin errs++; $display("FAIL rnd_b i=%0d got=%0d want=%0d", i, fwd_b_sel, e_b); end
         if (stall_count !== cnt_exp()) begin errs++; $display("FAIL rnd_cnt i=%0d got=%0d want=%0d", i, stall_count, cnt_exp()); end
      end
      rst = 0;
   endtask
   initial begin
      test_reset();
      test_alu_chain();
      test_distance2();
      test_load_use();
      test_x0();
      test_flush();
      test_reset_mid_stall();
      test_stall_count();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
